// File: rtl/ten_gig_tx_arbiter.sv
// Round-robin, packet-granular arbiter: P_SRC_NUM AXIS sources share one 10G channel TX.
// Define TEN_GIG_TX_ARB_STAT_EN to add per-source completed-packet counters on o_pkt_cnt.
module ten_gig_tx_arbiter #(
  parameter int unsigned P_SRC_NUM    = 4,
  parameter logic [14:0] P_MAX_LENGTH = 15'd9600
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_link_up,
  input  logic [P_SRC_NUM-1:0]     s_axis_tvalid,
  output logic [P_SRC_NUM-1:0]     s_axis_tready,
  input  logic [P_SRC_NUM-1:0]     s_axis_tlast,
  input  logic [P_SRC_NUM-1:0]     s_axis_tuser,
  input  logic [64*P_SRC_NUM-1:0]  s_axis_tdata,
  input  logic [8*P_SRC_NUM-1:0]   s_axis_tkeep,
  output logic                     m_axis_tvalid,
  output logic [63:0]              m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic [7:0]               m_axis_tkeep,
  output logic                     m_axis_tuser,
  input  logic                     m_axis_tready,
  output logic [P_SRC_NUM-1:0]     o_grant,
`ifdef TEN_GIG_TX_ARB_STAT_EN
  output logic [32*P_SRC_NUM-1:0]  o_pkt_cnt,
`endif
  output logic                     o_abort
);

  localparam int unsigned LP_MAX_BEATS = (32'(P_MAX_LENGTH) + 32'd7) / 32'd8;
  localparam logic [11:0] LP_LAST_BEAT = 12'(LP_MAX_BEATS - 32'd1);
  localparam int unsigned LP_IDX_W     = (P_SRC_NUM > 32'd1) ? $clog2(P_SRC_NUM) : 32'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [P_SRC_NUM-1:0]  grant_r, grant_nxt_s;
  logic [LP_IDX_W-1:0]   ptr_r, ptr_nxt_s;
  logic [11:0]           beat_cnt_r, beat_cnt_nxt_s;
  logic                  abort_r, abort_nxt_s;

  logic                  pick_found_s;
  logic [LP_IDX_W-1:0]   pick_idx_s;
  logic                  src_valid_s, src_last_s, src_user_s;
  logic [63:0]           src_data_s;
  logic [7:0]            src_keep_s;
  logic                  force_s, xfer_acc_s, drain_acc_s;

  // First requester at or after 'start', wrapping; returns {found, index}.
  function automatic logic [LP_IDX_W:0] rr_pick(input logic [P_SRC_NUM-1:0] req,
                                                input logic [LP_IDX_W-1:0]  start);
    logic                found;
    logic [LP_IDX_W-1:0] idx;
    int unsigned         cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < P_SRC_NUM; k++) begin
      cand = (32'(start) + k) % P_SRC_NUM;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = LP_IDX_W'(cand);
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  assign {pick_found_s, pick_idx_s} = rr_pick(s_axis_tvalid, ptr_r);

  // AND-OR mux of the granted source slice; grant_r is one-hot or zero.
  always_comb begin
    src_valid_s = |(s_axis_tvalid & grant_r);
    src_last_s  = |(s_axis_tlast  & grant_r);
    src_user_s  = |(s_axis_tuser  & grant_r);
    src_data_s  = 64'd0;
    src_keep_s  = 8'd0;
    for (int i = 0; i < int'(P_SRC_NUM); i++) begin
      src_data_s = src_data_s | (s_axis_tdata[i*64 +: 64] & {64{grant_r[i]}});
      src_keep_s = src_keep_s | (s_axis_tkeep[i*8 +: 8]   & {8{grant_r[i]}});
    end
  end

  // An oversize frame is cut on its last allowed beat unless the source ends it there anyway.
  assign force_s     = (state_r == ST_XFER) && (beat_cnt_r == LP_LAST_BEAT) && !src_last_s;
  assign xfer_acc_s  = (state_r == ST_XFER) && src_valid_s && m_axis_tready;
  assign drain_acc_s = (state_r == ST_DRAIN) && src_valid_s;

  // Channel-side outputs and source ready, driven only while a source owns the channel.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 64'd0;
    m_axis_tkeep  = 8'd0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = '0;
    case (state_r)
      ST_XFER: begin
        m_axis_tvalid = src_valid_s;
        m_axis_tdata  = src_data_s;
        m_axis_tkeep  = src_keep_s;
        m_axis_tlast  = src_last_s | force_s;
        m_axis_tuser  = src_user_s | force_s;
        s_axis_tready = grant_r & {P_SRC_NUM{m_axis_tready}};
      end
      ST_DRAIN: begin
        s_axis_tready = grant_r;
      end
      default: begin
        s_axis_tready = '0;
      end
    endcase
  end

  // Next-state logic: grant in IDLE, hold through the packet, discard the tail after truncation.
  always_comb begin
    state_nxt_s    = state_r;
    grant_nxt_s    = grant_r;
    ptr_nxt_s      = ptr_r;
    beat_cnt_nxt_s = beat_cnt_r;
    abort_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_link_up && pick_found_s) begin
          state_nxt_s    = ST_XFER;
          grant_nxt_s    = P_SRC_NUM'(1'b1) << pick_idx_s;
          ptr_nxt_s      = LP_IDX_W'((32'(pick_idx_s) + 32'd1) % P_SRC_NUM);
          beat_cnt_nxt_s = 12'd0;
        end else begin
          grant_nxt_s = '0;
        end
      end
      ST_XFER: begin
        if (xfer_acc_s) begin
          beat_cnt_nxt_s = beat_cnt_r + 12'd1;
          if (src_last_s) begin
            state_nxt_s = ST_IDLE;
            grant_nxt_s = '0;
          end else if (force_s) begin
            state_nxt_s = ST_DRAIN;
            abort_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_XFER;
          end
        end else begin
          state_nxt_s = ST_XFER;
        end
      end
      ST_DRAIN: begin
        if (drain_acc_s && src_last_s) begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = '0;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = '0;
      end
    endcase
  end

  // State, grant, round-robin pointer, beat counter and abort pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      grant_r    <= '0;
      ptr_r      <= '0;
      beat_cnt_r <= 12'd0;
      abort_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      grant_r    <= grant_nxt_s;
      ptr_r      <= ptr_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
      abort_r    <= abort_nxt_s;
    end
  end

  assign o_grant = grant_r;
  assign o_abort = abort_r;

`ifdef TEN_GIG_TX_ARB_STAT_EN
  logic [31:0] pkt_cnt_r [P_SRC_NUM];

  // Completed-packet counters; a truncated frame counts on its forced last beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(P_SRC_NUM); i++) begin
        pkt_cnt_r[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < int'(P_SRC_NUM); i++) begin
        if (xfer_acc_s && (src_last_s || force_s) && grant_r[i]) begin
          pkt_cnt_r[i] <= pkt_cnt_r[i] + 32'd1;
        end else begin
          pkt_cnt_r[i] <= pkt_cnt_r[i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < int'(P_SRC_NUM); gi++) begin : g_pkt_cnt
    assign o_pkt_cnt[gi*32 +: 32] = pkt_cnt_r[gi];
  end
`endif

endmodule

// File: tb/tb_ten_gig_tx_arbiter.sv
// Self-checking bench for ten_gig_tx_arbiter: arbitration vector table plus
// scoreboarded multi-cycle packet scenarios (order, truncation, link, backpressure, reset).
module tb_ten_gig_tx_arbiter;
  localparam int N    = 4;
  localparam int MAXB = 1200;

  logic            clk = 1'b0;
  logic            rst_n, link_up;
  logic [N-1:0]    s_tvalid, s_tready, s_tlast, s_tuser;
  logic [64*N-1:0] s_tdata;
  logic [8*N-1:0]  s_tkeep;
  logic            m_tvalid, m_tlast, m_tuser, m_tready;
  logic [63:0]     m_tdata;
  logic [7:0]      m_tkeep;
  logic [N-1:0]    grant;
  logic            abort;

  always #5 clk = ~clk;

  ten_gig_tx_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_link_up(link_up),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .o_grant(grant), .o_abort(abort)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  typedef struct {
    logic       link;
    logic [3:0] mask;
    logic [3:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int    len_q [N][$];
  beat_t exp_q [N][$];
  int    beat [N];
  int    done_cnt [N];
  int    enq_cnt [N];
  int    m_beats [N];
  int    src_acc [N];
  int    owner_seen [$];
  int    owner_exp [$];
  int    abort_cnt, cyc, last_end_cyc, cur_owner;
  logic  in_pkt, gap_chk, bp_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk_data(input int src, input int sq, input int bt);
    logic [31:0] s32, q32, b32;
    s32 = src; q32 = sq; b32 = bt;
    return {s32[7:0], q32[7:0], b32[15:0], (b32 * 32'h9E37_79B1) ^ q32};
  endfunction

  function automatic logic [7:0] mk_keep(input int bt, input int len);
    return (bt == len - 1) ? 8'h0F : 8'hFF;
  endfunction

  function automatic logic mk_user(input int sq, input int bt, input int len);
    return ((sq % 2) == 1) && (bt == len - 1);
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic model_empty();
    logic e;
    e = 1'b1;
    for (int i = 0; i < N; i++) if (len_q[i].size() != 0 || exp_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      len_q[i].delete(); exp_q[i].delete();
      beat[i] = 0; done_cnt[i] = 0; enq_cnt[i] = 0; m_beats[i] = 0; src_acc[i] = 0;
    end
    owner_seen.delete(); owner_exp.delete();
    abort_cnt = 0; cyc = 0; last_end_cyc = -1; cur_owner = -1;
    in_pkt = 1'b0; gap_chk = 1'b0; bp_en = 1'b0;
  endtask

  // Enqueue a packet at a source and its expected channel-side beats (truncated if oversize).
  task automatic queue_pkt(input int src, input int len);
    int sq, out_len;
    beat_t e;
    sq = enq_cnt[src]; enq_cnt[src]++;
    len_q[src].push_back(len);
    out_len = (len > MAXB) ? MAXB : len;
    for (int b = 0; b < out_len; b++) begin
      e.d = mk_data(src, sq, b);
      e.k = mk_keep(b, len);
      e.l = (b == len - 1) || (b == MAXB - 1);
      e.u = mk_user(sq, b, len) | ((len > MAXB) && (b == MAXB - 1));
      exp_q[src].push_back(e);
    end
  endtask

  task automatic drive_sources();
    int L, b;
    for (int i = 0; i < N; i++) begin
      if (len_q[i].size() > 0) begin
        L = len_q[i][0]; b = beat[i];
        s_tvalid[i] = 1'b1;
        s_tdata[i*64 +: 64] = mk_data(i, done_cnt[i], b);
        s_tkeep[i*8 +: 8]   = mk_keep(b, L);
        s_tlast[i] = (b == L - 1);
        s_tuser[i] = mk_user(done_cnt[i], b, L);
      end else begin
        s_tvalid[i] = 1'b0; s_tdata[i*64 +: 64] = 64'd0;
        s_tkeep[i*8 +: 8] = 8'd0; s_tlast[i] = 1'b0; s_tuser[i] = 1'b0;
      end
    end
  endtask

  task automatic monitor_beat();
    int g;
    beat_t e;
    g = onehot_idx(grant);
    check("beat_grant_onehot", 64'($onehot(grant)), 64'd1);
    if (g >= 0) begin
      m_beats[g]++;
      if (!in_pkt) begin
        owner_seen.push_back(g);
        if (gap_chk && last_end_cyc >= 0) check("pkt_gap", 64'(cyc - last_end_cyc), 64'd2);
        in_pkt = 1'b1; cur_owner = g;
      end else begin
        check("no_interleave", 64'(g), 64'(cur_owner));
      end
      if (exp_q[g].size() == 0) begin
        check("extra_beat", 64'(g), 64'hFFFF);
      end else begin
        e = exp_q[g].pop_front();
        check("beat_data", m_tdata, e.d);
        check("beat_keep", 64'(m_tkeep), 64'(e.k));
        check("beat_last", 64'(m_tlast), 64'(e.l));
        check("beat_user", 64'(m_tuser), 64'(e.u));
      end
      if (m_tlast) begin
        in_pkt = 1'b0; last_end_cyc = cyc;
      end
    end
  endtask

  // One clock: sample handshakes at negedge, then advance the source model after posedge.
  task automatic cycle();
    logic [N-1:0] acc;
    @(negedge clk);
    check("grant_onehot0", 64'($onehot0(grant)), 64'd1);
    if (abort) abort_cnt++;
    if (m_tvalid && m_tready) monitor_beat();
    acc = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        src_acc[i]++;
        beat[i]++;
        if (beat[i] == len_q[i][0]) begin
          len_q[i].delete(0); beat[i] = 0; done_cnt[i]++;
        end
      end
    end
    cyc++;
    m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    drive_sources();
  endtask

  task automatic run_until_done(input string name, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (model_empty()) break;
      cycle();
    end
    check({name, "_timeout"}, 64'(model_empty()), 64'd1);
    cycle();
    check({name, "_idle_after"}, 64'(grant), 64'd0);
  endtask

  task automatic check_order(input string name);
    check({name, "_pkt_count"}, 64'(owner_seen.size()), 64'(owner_exp.size()));
    for (int i = 0; i < owner_exp.size() && i < owner_seen.size(); i++)
      check({name, "_owner"}, 64'(owner_seen[i]), 64'(owner_exp[i]));
  endtask

  // Assert reset, verify all outputs are quiet, drop the model, release on a clean edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_abort", 64'(abort), 64'd0);
    clear_model();
    m_tready = 1'b1;
    drive_sources();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b1, 4'b1111, 4'b0001};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0010};
    tbl[2]  = '{1'b1, 4'b1111, 4'b0100};
    tbl[3]  = '{1'b1, 4'b1111, 4'b1000};
    tbl[4]  = '{1'b1, 4'b1010, 4'b0010};
    tbl[5]  = '{1'b1, 4'b0011, 4'b0001};
    tbl[6]  = '{1'b1, 4'b1000, 4'b1000};
    tbl[7]  = '{1'b0, 4'b1111, 4'b0000};
    tbl[8]  = '{1'b1, 4'b0100, 4'b0100};
    tbl[9]  = '{1'b1, 4'b0001, 4'b0001};
    tbl[10] = '{1'b1, 4'b0110, 4'b0010};
    tbl[11] = '{1'b1, 4'b0110, 4'b0100};

    rst_n = 1'b0; link_up = 1'b1; m_tready = 1'b1;
    s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0; s_tkeep = '0;
    do_reset();

    // Single-beat arbitration vectors; the pointer carries over between rows.
    for (int v = 0; v < 12; v++) begin
      int gi;
      link_up = tbl[v].link;
      s_tvalid = tbl[v].mask; s_tlast = '1; s_tuser = '0; s_tkeep = '1;
      for (int i = 0; i < N; i++) s_tdata[i*64 +: 64] = mk_data(i, v, 0);
      @(posedge clk); #1;
      gi = onehot_idx(tbl[v].exp);
      check("tbl_grant", 64'(grant), 64'(tbl[v].exp));
      check("tbl_tready", 64'(s_tready), 64'(tbl[v].exp));
      check("tbl_m_tvalid", 64'(m_tvalid), 64'(|tbl[v].exp));
      check("tbl_m_tlast", 64'(m_tlast), 64'(|tbl[v].exp));
      check("tbl_m_tdata", m_tdata, (gi >= 0) ? mk_data(gi, v, 0) : 64'd0);
      @(posedge clk); #1;
      s_tvalid = '0;
      check("tbl_idle_after", 64'(grant), 64'd0);
    end
    link_up = 1'b1;

    // Four simultaneous 8-beat packets: strict order with one idle cycle between them.
    do_reset();
    for (int i = 0; i < N; i++) queue_pkt(i, 8);
    owner_exp = '{0, 1, 2, 3};
    gap_chk = 1'b1;
    drive_sources();
    run_until_done("rr4", 200);
    check_order("rr4");

    // Source 2 back-to-back against one packet from source 0.
    do_reset();
    queue_pkt(0, 4);
    for (int p = 0; p < 3; p++) queue_pkt(2, 4);
    owner_exp = '{0, 2, 2, 2};
    drive_sources();
    run_until_done("b2b", 200);
    check_order("b2b");

    // Oversize packet on source 1 is truncated to 1200 beats, tail drained, then source 2 served.
    do_reset();
    queue_pkt(1, 1300);
    queue_pkt(2, 4);
    owner_exp = '{1, 2};
    drive_sources();
    run_until_done("trunc", 3000);
    check_order("trunc");
    check("trunc_abort_pulses", 64'(abort_cnt), 64'd1);
    check("trunc_out_beats", 64'(m_beats[1]), 64'(MAXB));
    check("trunc_drained", 64'(src_acc[1] - m_beats[1]), 64'd100);

    // Link gating: no grant while down, grant the cycle after it rises, no cut mid-packet.
    do_reset();
    link_up = 1'b0;
    queue_pkt(3, 6);
    drive_sources();
    repeat (4) cycle();
    check("link_down_grant", 64'(grant), 64'd0);
    check("link_down_m_tvalid", 64'(m_tvalid), 64'd0);
    link_up = 1'b1;
    cycle();
    check("link_up_grant", 64'(grant), 64'b1000);
    cycle();
    cycle();
    link_up = 1'b0;
    run_until_done("link_mid", 100);
    queue_pkt(0, 2);
    drive_sources();
    repeat (5) cycle();
    check("link_blocks_grant", 64'(grant), 64'd0);
    check("link_blocks_beats", 64'(exp_q[0].size()), 64'd2);
    link_up = 1'b1;
    run_until_done("link_resume", 100);
    owner_exp = '{3, 0};
    check_order("link");

    // Random 50% backpressure on 64-beat packets, two per source.
    do_reset();
    bp_en = 1'b1;
    for (int p = 0; p < 2; p++) for (int i = 0; i < N; i++) queue_pkt(i, 64);
    owner_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
    drive_sources();
    run_until_done("bp", 4000);
    check_order("bp");

    // Reset at beat 5 of a source-2 packet; afterwards arbitration restarts at source 0.
    do_reset();
    queue_pkt(2, 10);
    drive_sources();
    for (int c = 0; c < 50; c++) begin
      if (m_beats[2] >= 5) break;
      cycle();
    end
    check("mid_rst_progress", 64'(m_beats[2]), 64'd5);
    check("mid_rst_granted", 64'(grant), 64'b0100);
    do_reset();
    for (int i = 0; i < N; i++) queue_pkt(i, 2);
    owner_exp = '{0, 1, 2, 3};
    drive_sources();
    run_until_done("post_rst", 200);
    check_order("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so a stuck DUT still reaches a verdict.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete (checks %0d errors %0d)", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
